// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and constants for the two-master bus arbiter
package bus_arb_pkg;

    localparam int DEF_ADDR_W = 27;
    localparam int DEF_DATA_W = 32;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - master-side, memory-side and status signals of the bus arbiter
interface bus_arbiter_if import bus_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_data;
    logic              m0_we;
    logic              m0_start;
    logic [DATA_W-1:0] m0_q;
    logic              m0_done;

    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_data;
    logic              m1_we;
    logic              m1_start;
    logic [DATA_W-1:0] m1_q;
    logic              m1_done;

    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data;
    logic              bus_we;
    logic              bus_start;
    logic [DATA_W-1:0] bus_q;
    logic              bus_done;

    logic              grant;
    logic              busy;
    logic              err;

    // Arbiter view: takes requests and memory responses, drives everything else.
    modport slave (
        input  m0_addr, m0_data, m0_we, m0_start,
        input  m1_addr, m1_data, m1_we, m1_start,
        input  bus_q, bus_done,
        output m0_q, m0_done, m1_q, m1_done,
        output bus_addr, bus_data, bus_we, bus_start,
        output grant, busy, err
    );

    // Environment view: the two bus masters plus the memory unit.
    modport master (
        output m0_addr, m0_data, m0_we, m0_start,
        output m1_addr, m1_data, m1_we, m1_start,
        output bus_q, bus_done,
        input  m0_q, m0_done, m1_q, m1_done,
        input  bus_addr, bus_data, bus_we, bus_start,
        input  grant, busy, err
    );

endinterface

// File: rtl/bus_req_latch.sv
// rtl/bus_req_latch.sv - one-deep request holder for a single bus master
module bus_req_latch import bus_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              we_in,
    input  logic              clear,
    input  logic              in_flight,
    output logic              pend,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              we,
    output logic              err_pulse
);

    logic accept;

    // A master owns at most one request: a second start while one is queued
    // or on the bus is dropped and flagged.
    assign err_pulse = start && (pend || in_flight);
    assign accept    = start && !pend && !in_flight;

    // Hold the request fields until the arbiter issues them onto the bus.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            pend <= 1'b0;
            addr <= '0;
            data <= '0;
            we   <= 1'b0;
        end else if (clear) begin
            pend <= 1'b0;
        end else if (accept) begin
            pend <= 1'b1;
            addr <= addr_in;
            data <= data_in;
            we   <= we_in;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - serialises two masters onto one start/done memory bus
module bus_arbiter import bus_arb_pkg::*; #(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic         clk,
    input  logic         nreset,
    bus_arbiter_if.slave bif
);

    arb_state_t        state;
    logic              last_grant;
    logic              flush;

    logic              pend0, pend1;
    logic              we0_l, we1_l;
    logic              err0, err1;
    logic [ADDR_W-1:0] addr0_l, addr1_l;
    logic [DATA_W-1:0] data0_l, data1_l;

    logic              in_xfer;
    logic              req0, req1;
    logic              win;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              win_we;

    assign in_xfer = (state == ST_REQ) || (state == ST_WAIT);

    bus_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req0 (
        .clk       (clk),
        .nreset    (nreset),
        .start     (bif.m0_start),
        .addr_in   (bif.m0_addr),
        .data_in   (bif.m0_data),
        .we_in     (bif.m0_we),
        .clear     ((state == ST_REQ) && (bif.grant == M_CPU)),
        .in_flight (in_xfer && (bif.grant == M_CPU)),
        .pend      (pend0),
        .addr      (addr0_l),
        .data      (data0_l),
        .we        (we0_l),
        .err_pulse (err0)
    );

    bus_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req1 (
        .clk       (clk),
        .nreset    (nreset),
        .start     (bif.m1_start),
        .addr_in   (bif.m1_addr),
        .data_in   (bif.m1_data),
        .we_in     (bif.m1_we),
        .clear     ((state == ST_REQ) && (bif.grant == M_AUX)),
        .in_flight (in_xfer && (bif.grant == M_AUX)),
        .pend      (pend1),
        .addr      (addr1_l),
        .data      (data1_l),
        .we        (we1_l),
        .err_pulse (err1)
    );

    // Pick the next owner; a start arriving this cycle bypasses its latch so
    // an idle bus issues on the very next cycle.
    always_comb begin
        req0 = pend0 || bif.m0_start;
        req1 = pend1 || bif.m1_start;
        if (req0 && req1) begin
            win = (FIXED_PRIO != 0) ? M_CPU : ~last_grant;
        end else begin
            win = req1 ? M_AUX : M_CPU;
        end
        if (win == M_AUX) begin
            win_addr = pend1 ? addr1_l : bif.m1_addr;
            win_data = pend1 ? data1_l : bif.m1_data;
            win_we   = pend1 ? we1_l   : bif.m1_we;
        end else begin
            win_addr = pend0 ? addr0_l : bif.m0_addr;
            win_data = pend0 ? data0_l : bif.m0_data;
            win_we   = pend0 ? we0_l   : bif.m0_we;
        end
    end

    // Transfer sequencer: issue, wait for done, route the response back.
    // flush absorbs the one late done that a transfer abandoned by reset may
    // still deliver, so it is not mistaken for a protocol error.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state         <= ST_IDLE;
            last_grant    <= M_AUX;
            flush         <= 1'b1;
            bif.bus_addr  <= '0;
            bif.bus_data  <= '0;
            bif.bus_we    <= 1'b0;
            bif.bus_start <= 1'b0;
            bif.grant     <= M_CPU;
            bif.busy      <= 1'b0;
            bif.err       <= 1'b0;
            bif.m0_q      <= '0;
            bif.m0_done   <= 1'b0;
            bif.m1_q      <= '0;
            bif.m1_done   <= 1'b0;
        end else begin
            bif.bus_start <= 1'b0;
            bif.m0_done   <= 1'b0;
            bif.m1_done   <= 1'b0;
            if (err0 || err1) begin
                bif.err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (bif.bus_done) begin
                        if (!flush) begin
                            bif.err <= 1'b1;
                        end
                        flush <= 1'b0;
                    end
                    if (req0 || req1) begin
                        state         <= ST_REQ;
                        flush         <= 1'b0;
                        bif.bus_start <= 1'b1;
                        bif.busy      <= 1'b1;
                        bif.grant     <= win;
                        bif.bus_addr  <= win_addr;
                        bif.bus_data  <= win_data;
                        bif.bus_we    <= win_we;
                    end
                end
                ST_REQ: begin
                    state <= ST_WAIT;
                    if (bif.bus_done) begin
                        bif.err <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bif.bus_done) begin
                        state      <= ST_IDLE;
                        bif.busy   <= 1'b0;
                        last_grant <= bif.grant;
                        if (bif.grant == M_AUX) begin
                            bif.m1_q    <= bif.bus_q;
                            bif.m1_done <= 1'b1;
                        end else begin
                            bif.m0_q    <= bif.bus_q;
                            bif.m0_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - bench for bus_arbiter, round-robin and fixed-priority instances
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        nreset;

    logic [26:0] s_addr  [2][2];
    logic [31:0] s_data  [2][2];
    logic        s_we    [2][2];
    logic        s_start [2][2];
    logic [31:0] s_bq    [2];
    logic        s_bdone [2];

    logic        o_bus_start [2];
    logic        o_bus_we    [2];
    logic        o_grant     [2];
    logic        o_busy      [2];
    logic        o_err       [2];
    logic [26:0] o_bus_addr  [2];
    logic [31:0] o_bus_data  [2];
    logic        o_done      [2][2];
    logic [31:0] o_q         [2][2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance 0 is round-robin, instance 1 is fixed priority.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        bus_arbiter_if #(.ADDR_W(27), .DATA_W(32)) bif ();
        assign bif.m0_addr    = s_addr[g][0];
        assign bif.m0_data    = s_data[g][0];
        assign bif.m0_we      = s_we[g][0];
        assign bif.m0_start   = s_start[g][0];
        assign bif.m1_addr    = s_addr[g][1];
        assign bif.m1_data    = s_data[g][1];
        assign bif.m1_we      = s_we[g][1];
        assign bif.m1_start   = s_start[g][1];
        assign bif.bus_q      = s_bq[g];
        assign bif.bus_done   = s_bdone[g];
        assign o_bus_start[g] = bif.bus_start;
        assign o_bus_we[g]    = bif.bus_we;
        assign o_bus_addr[g]  = bif.bus_addr;
        assign o_bus_data[g]  = bif.bus_data;
        assign o_grant[g]     = bif.grant;
        assign o_busy[g]      = bif.busy;
        assign o_err[g]       = bif.err;
        assign o_done[g][0]   = bif.m0_done;
        assign o_done[g][1]   = bif.m1_done;
        assign o_q[g][0]      = bif.m0_q;
        assign o_q[g][1]      = bif.m1_q;
        bus_arbiter #(.ADDR_W(27), .DATA_W(32), .FIXED_PRIO(g)) u_dut (
            .clk    (clk),
            .nreset (nreset),
            .bif    (bif)
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each master has at most one outstanding request (queued
    // or owned by the bus); the bus is free, issuing, or waiting for done.
    bit          mr_pend [2][2];
    logic [26:0] mr_addr [2][2];
    logic [31:0] mr_data [2][2];
    logic        mr_we   [2][2];
    int          m_phase [2];
    logic        m_last  [2];
    bit          m_absorb[2];
    logic        e_bus_start[2], e_we[2], e_grant[2], e_busy[2], e_err[2];
    logic [26:0] e_addr[2];
    logic [31:0] e_data[2];
    logic        e_done[2][2];
    logic [31:0] e_q[2][2];
    bit          primed = 0;
    int          mw, mg;

    // Compare against the prediction for the last edge, then predict the next
    // edge from the inputs it is about to sample.
    always @(negedge clk) begin
        if (primed) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d_bus_start", d), o_bus_start[d], e_bus_start[d]);
                chk($sformatf("d%0d_bus_addr", d), o_bus_addr[d], e_addr[d]);
                chk($sformatf("d%0d_bus_data", d), o_bus_data[d], e_data[d]);
                chk($sformatf("d%0d_bus_we", d), o_bus_we[d], e_we[d]);
                chk($sformatf("d%0d_grant", d), o_grant[d], e_grant[d]);
                chk($sformatf("d%0d_busy", d), o_busy[d], e_busy[d]);
                chk($sformatf("d%0d_err", d), o_err[d], e_err[d]);
                chk($sformatf("d%0d_m0_done", d), o_done[d][0], e_done[d][0]);
                chk($sformatf("d%0d_m1_done", d), o_done[d][1], e_done[d][1]);
                chk($sformatf("d%0d_m0_q", d), o_q[d][0], e_q[d][0]);
                chk($sformatf("d%0d_m1_q", d), o_q[d][1], e_q[d][1]);
            end
        end
        primed = 1;
        for (int d = 0; d < 2; d++) begin
            if (!nreset) begin
                e_bus_start[d] = 0; e_addr[d] = '0; e_data[d] = '0; e_we[d] = 0;
                e_grant[d] = 0; e_busy[d] = 0; e_err[d] = 0;
                for (int m = 0; m < 2; m++) begin
                    e_done[d][m] = 0; e_q[d][m] = '0; mr_pend[d][m] = 0;
                end
                m_phase[d] = 0; m_last[d] = 1; m_absorb[d] = 1;
            end else begin
                e_bus_start[d] = 0;
                e_done[d][0] = 0;
                e_done[d][1] = 0;
                for (int m = 0; m < 2; m++) begin
                    if (s_start[d][m]) begin
                        if (mr_pend[d][m] || (m_phase[d] != 0 && int'(e_grant[d]) == m)) begin
                            e_err[d] = 1;
                        end else begin
                            mr_pend[d][m] = 1;
                            mr_addr[d][m] = s_addr[d][m];
                            mr_data[d][m] = s_data[d][m];
                            mr_we[d][m]   = s_we[d][m];
                        end
                    end
                end
                if (m_phase[d] == 0) begin
                    if (s_bdone[d]) begin
                        if (!m_absorb[d]) e_err[d] = 1;
                        m_absorb[d] = 0;
                    end
                    if (mr_pend[d][0] || mr_pend[d][1]) begin
                        if (mr_pend[d][0] && mr_pend[d][1]) mw = (d == 1) ? 0 : (m_last[d] ? 0 : 1);
                        else mw = mr_pend[d][1] ? 1 : 0;
                        mr_pend[d][mw] = 0;
                        e_addr[d] = mr_addr[d][mw];
                        e_data[d] = mr_data[d][mw];
                        e_we[d]   = mr_we[d][mw];
                        e_grant[d] = mw[0];
                        e_bus_start[d] = 1;
                        e_busy[d] = 1;
                        m_phase[d] = 1;
                        m_absorb[d] = 0;
                    end
                end else if (m_phase[d] == 1) begin
                    if (s_bdone[d]) e_err[d] = 1;
                    m_phase[d] = 2;
                end else if (s_bdone[d]) begin
                    mg = int'(e_grant[d]);
                    e_q[d][mg] = s_bq[d];
                    e_done[d][mg] = 1;
                    m_last[d] = e_grant[d];
                    m_phase[d] = 0;
                    e_busy[d] = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input int d, input int m, input logic [26:0] a, input logic [31:0] dt, input logic we);
        s_addr[d][m]  = a;
        s_data[d][m]  = dt;
        s_we[d][m]    = we;
        s_start[d][m] = 1'b1;
    endtask

    task automatic clr_starts();
        for (int d = 0; d < 2; d++) begin
            s_start[d][0] = 1'b0;
            s_start[d][1] = 1'b0;
        end
    endtask

    task automatic pulse_done(input int d, input logic [31:0] q);
        s_bq[d]    = q;
        s_bdone[d] = 1'b1;
        step();
        s_bdone[d] = 1'b0;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        step();
        nreset = 1'b1;
    endtask

    task automatic wait_start(input int d, input string name);
        bit found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (o_bus_start[d]) found = 1;
            else step();
        end
        if (!found) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic fairness(input int d, input logic [5:0] exp_g);
        start_req(d, 0, 27'h40, 32'h40, 1'b0);
        start_req(d, 1, 27'h50, 32'h50, 1'b0);
        step();
        clr_starts();
        for (int k = 0; k < 6; k++) begin
            wait_start(d, $sformatf("fair_d%0d_k%0d", d, k));
            chk($sformatf("fair_d%0d_grant%0d", d, k), o_grant[d], exp_g[k]);
            step();
            pulse_done(d, 32'h100 + k);
            if (k < 5) begin
                start_req(d, int'(exp_g[k]), 27'h40 + 27'(exp_g[k]) * 27'h10, 32'h0, 1'b0);
                step();
                clr_starts();
            end
        end
        do_reset();
    endtask

    int n_starts;
    bit hold_ok;

    initial begin
        nreset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            s_bq[d] = '0;
            s_bdone[d] = 1'b0;
            for (int m = 0; m < 2; m++) begin
                s_addr[d][m] = '0; s_data[d][m] = '0; s_we[d][m] = 1'b0; s_start[d][m] = 1'b0;
            end
        end
        step();
        step();
        chk("rst_bus_start", o_bus_start[0], 0);
        chk("rst_busy", o_busy[0], 0);
        chk("rst_grant", o_grant[0], 0);
        chk("rst_err", o_err[0], 0);
        nreset = 1'b1;
        step();

        // single read
        start_req(0, 0, 27'h0000100, 32'h0, 1'b0);
        step();
        clr_starts();
        chk("rd_bus_start", o_bus_start[0], 1);
        chk("rd_bus_addr", o_bus_addr[0], 27'h100);
        chk("rd_bus_we", o_bus_we[0], 0);
        repeat (4) step();
        pulse_done(0, 32'hCAFEBABE);
        chk("rd_m0_done", o_done[0][0], 1);
        chk("rd_m0_q", o_q[0][0], 32'hCAFEBABE);
        chk("rd_m1_done", o_done[0][1], 0);
        step();
        chk("rd_m0_done_clr", o_done[0][0], 0);
        chk("rd_m0_q_hold", o_q[0][0], 32'hCAFEBABE);

        // simultaneous starts after reset
        do_reset();
        start_req(0, 0, 27'h10, 32'h1, 1'b0);
        start_req(0, 1, 27'h20, 32'h2, 1'b0);
        step();
        clr_starts();
        chk("sim_first_start", o_bus_start[0], 1);
        chk("sim_first_addr", o_bus_addr[0], 27'h10);
        chk("sim_first_grant", o_grant[0], 0);
        step();
        step();
        pulse_done(0, 32'h11);
        chk("sim_m0_q", o_q[0][0], 32'h11);
        step();
        chk("sim_second_start", o_bus_start[0], 1);
        chk("sim_second_addr", o_bus_addr[0], 27'h20);
        chk("sim_second_grant", o_grant[0], 1);
        step();
        pulse_done(0, 32'h22);
        chk("sim_m1_done", o_done[0][1], 1);
        chk("sim_m1_q", o_q[0][1], 32'h22);

        // write hold with a long done delay
        start_req(0, 1, 27'h7FFFFFF, 32'hFFFFFFFF, 1'b1);
        step();
        clr_starts();
        chk("wr_start", o_bus_start[0], 1);
        n_starts = 1;
        hold_ok = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_bus_start[0]) n_starts++;
            if (o_bus_addr[0] !== 27'h7FFFFFF || o_bus_data[0] !== 32'hFFFFFFFF || o_bus_we[0] !== 1'b1) hold_ok = 0;
        end
        pulse_done(0, 32'h5);
        chk("wr_hold", hold_ok, 1);
        chk("wr_start_once", n_starts, 1);
        chk("wr_m1_done", o_done[0][1], 1);

        // fairness: round-robin alternates, fixed priority keeps master 0
        fairness(0, 6'b101010);
        fairness(1, 6'b000000);

        // duplicate start while in flight
        start_req(0, 0, 27'h60, 32'h0, 1'b0);
        step();
        clr_starts();
        start_req(0, 0, 27'h61, 32'h0, 1'b0);
        step();
        clr_starts();
        chk("dup_err", o_err[0], 1);
        step();
        pulse_done(0, 32'h66);
        chk("dup_m0_q", o_q[0][0], 32'h66);
        n_starts = 0;
        repeat (6) begin
            step();
            if (o_bus_start[0]) n_starts++;
        end
        chk("dup_dropped", n_starts, 0);
        chk("err_sticky", o_err[0], 1);
        do_reset();
        chk("err_cleared", o_err[0], 0);

        // stray done in idle after a clean transfer
        start_req(0, 1, 27'h90, 32'h0, 1'b0);
        step();
        clr_starts();
        step();
        pulse_done(0, 32'h99);
        chk("clean_err", o_err[0], 0);
        pulse_done(0, 32'hBAD);
        chk("stray_err", o_err[0], 1);
        chk("stray_m0_done", o_done[0][0], 0);
        chk("stray_m1_done", o_done[0][1], 0);

        // reset during WAIT, late done absorbed
        do_reset();
        start_req(0, 0, 27'h70, 32'h7, 1'b1);
        step();
        clr_starts();
        step();
        step();
        do_reset();
        chk("mid_rst_busy", o_busy[0], 0);
        chk("mid_rst_addr", o_bus_addr[0], 0);
        chk("mid_rst_we", o_bus_we[0], 0);
        pulse_done(0, 32'hDEAD);
        chk("late_done_m0", o_done[0][0], 0);
        chk("late_done_err", o_err[0], 0);
        start_req(0, 0, 27'h80, 32'h0, 1'b0);
        step();
        clr_starts();
        chk("post_rst_start", o_bus_start[0], 1);
        chk("post_rst_addr", o_bus_addr[0], 27'h80);
        step();
        pulse_done(0, 32'h88);
        chk("post_rst_q", o_q[0][0], 32'h88);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Two-master arbiter that shares the single MemoryUnit bus (27-bit address, 32-bit data, start/done handshake) between the CPU (master 0) and a second bus master (master 1), such as a future DMA or blitter engine. It sits between the masters and the MemoryUnit bus port. It latches single-cycle start requests from each master and serialises them onto the bus with round-robin (or fixed) priority. It then routes bus_q and the bus_done pulse back to the master that owns the transfer.

Parameters:
ADDR_W, 27, bus address width
DATA_W, 32, bus data width
FIXED_PRIO, 0, 0 = round-robin on contention; 1 = master 0 always wins

Ports:
clk  in  1  system clock
nreset  in  1  synchronous active-low reset
m0_addr  in  ADDR_W  master 0 address, sampled when m0_start=1
m0_data  in  DATA_W  master 0 write data, sampled when m0_start=1
m0_we  in  1  master 0 write enable, sampled when m0_start=1
m0_start  in  1  master 0 request pulse (one cycle)
m0_q  out  DATA_W  master 0 read data, valid when m0_done=1
m0_done  out  1  master 0 completion pulse (one cycle)
m1_addr, m1_data, m1_we, m1_start, m1_q, m1_done  (same as master 0, for master 1)
bus_addr  out  ADDR_W  to MemoryUnit
bus_data  out  DATA_W  to MemoryUnit
bus_we  out  1  to MemoryUnit
bus_start  out  1  to MemoryUnit, one-cycle pulse
bus_q  in  DATA_W  from MemoryUnit
bus_done  in  1  from MemoryUnit, one-cycle pulse
grant  out  1  master that owns the current or last transfer
busy  out  1  high in REQ and WAIT states
err  out  1  sticky protocol-error flag

Behaviour:
- Reset (nreset=0 at a clk edge; takes effect from that edge, including mid-transfer):
  - all outputs 0; state IDLE; both pending flags cleared.
  - last_grant=1, so master 0 wins the first tie.
  - A bus_done arriving after reset while in IDLE is ignored and does not set err.
- Request capture, per master:
  - On mX_start=1 with no request pending or in flight for that master, latch addr/data/we and set pendX.
  - On mX_start=1 while that master already has a request pending or in flight: the request is dropped and err is set.
- State machine:
  - IDLE: if (pend0|m0_start) or (pend1|m1_start), select a winner, load bus_addr/data/we from it (bypassing the latch when the start is in this cycle), set grant, go to REQ. Otherwise stay.
  - REQ: bus_start=1 for exactly this cycle; clear the winner's pend flag; go to WAIT.
  - WAIT: bus_addr/data/we are held stable. On bus_done: register bus_q into mG_q, pulse mG_done for one cycle (where G = grant), set last_grant=G, go to IDLE.
- Winner selection:
  - Only one master requesting: that master wins.
  - Both requesting with FIXED_PRIO=0: the master != last_grant wins.
  - Both requesting with FIXED_PRIO=1: master 0 wins.
- Latency:
  - Start at cycle T with the bus idle: bus_start at T+1.
  - bus_done at cycle D: mG_done and mG_q valid at D+1; state is IDLE at D+1.
  - A pending request gets bus_start at D+2.
- mX_q holds its last value between transfers. mX_done is never asserted for the non-granted master.
- bus_done sampled in IDLE or REQ (stray): ignored and sets err.
- Simultaneous m0_start and m1_start in IDLE: one master is issued, the other is latched pending. No request is ever lost or duplicated.
- A start from the granted master in the same cycle as bus_done is a protocol error (transfer still in flight): dropped, err set.
- Width rules: no arithmetic; all paths are straight ADDR_W/DATA_W registers.

Decomposition:
- Package bus_arb_pkg: state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2); default widths ADDR_W=27, DATA_W=32; master index constants M_CPU=0, M_AUX=1.
- Sub-module bus_req_latch, instantiated once per master. It holds addr/data/we and the pend flag. Inputs: start, clear (from the top FSM), plus an in-flight indication from the top FSM for protocol-error detection. Outputs: pend, latched fields, error pulse. The FSM and routing stay in the top module.

Test Plan:
- Single read: m0_start at T with addr=0x0000100, we=0. Expect bus_start at T+1 with bus_addr=0x0000100. Drive bus_done at T+5 with bus_q=0xCAFEBABE. Expect m0_done=1 and m0_q=0xCAFEBABE at T+6; m1_done stays 0.
- Simultaneous starts after reset: m0 addr=0x10, m1 addr=0x20 at T. Expect bus_start with 0x10 at T+1 (grant=0). Return done; expect second bus_start with 0x20 two cycles after that done (grant=1).
- Round-robin fairness: both masters re-request immediately after every done, for 6 transfers. Grants alternate 0,1,0,1,0,1. With FIXED_PRIO=1 the same stimulus gives all grants 0 while m0 keeps requesting.
- Write hold: m1 write addr=0x7FFFFFF, data=0xFFFFFFFF, we=1; 10-cycle done delay. bus_addr/bus_data/bus_we stay constant from T+1 until bus_done; bus_start is high for exactly 1 cycle.
- Protocol errors: m0_start twice before done → err=1, only one bus_start issued. Separately, a stray bus_done in IDLE → err=1 and no mX_done pulse. err stays 1 until nreset=0.
- Reset mid-transfer: nreset=0 during WAIT. Next cycle all outputs are 0 and state is IDLE. A late bus_done produces no mX_done and leaves err=0. A new m0_start then issues normally.
